// File: rtl/demux.sv
// 1-to-2 valid/ready demultiplexer: single-entry input stage S0 feeding one
// output register per port, with per-port 16-bit transfer counters.
module demux #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_sel,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_a,
    output logic             o_out_a_valid,
    input  logic             i_out_a_ready,
    output logic [WIDTH-1:0] o_out_b,
    output logic             o_out_b_valid,
    input  logic             i_out_b_ready,
    output logic [15:0]      o_count_a,
    output logic [15:0]      o_count_b
);

    logic [WIDTH-1:0] r_s0_data;
    logic             r_s0_sel;
    logic             r_s0_valid;
    logic [WIDTH-1:0] r_a_data;
    logic             r_a_valid;
    logic [WIDTH-1:0] r_b_data;
    logic             r_b_valid;
    logic [15:0]      r_count_a;
    logic [15:0]      r_count_b;

    logic w_a_xfer;
    logic w_b_xfer;
    logic w_a_free;
    logic w_b_free;
    logic w_s0_adv;
    logic w_s0_to_a;
    logic w_s0_to_b;
    logic w_in_xfer;

    assign w_a_xfer = r_a_valid & i_out_a_ready;
    assign w_b_xfer = r_b_valid & i_out_b_ready;

    // A port can take the S0 word if empty or emptying on this same edge.
    assign w_a_free = ~r_a_valid | i_out_a_ready;
    assign w_b_free = ~r_b_valid | i_out_b_ready;

    assign w_s0_adv  = r_s0_valid & (r_s0_sel ? w_b_free : w_a_free);
    assign w_s0_to_a = w_s0_adv & ~r_s0_sel;
    assign w_s0_to_b = w_s0_adv & r_s0_sel;

    assign o_in_ready = ~r_s0_valid | w_s0_adv;
    assign w_in_xfer  = i_in_valid & o_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s0_data  <= '0;
            r_s0_sel   <= 1'b0;
            r_s0_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_s0_data  <= i_in;
            r_s0_sel   <= i_sel;
            r_s0_valid <= 1'b1;
        end else if (w_s0_adv) begin
            r_s0_valid <= 1'b0;
        end
    end

    // A reload on the same edge as a drain keeps valid high with no bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_data  <= '0;
            r_a_valid <= 1'b0;
        end else if (w_s0_to_a) begin
            r_a_data  <= r_s0_data;
            r_a_valid <= 1'b1;
        end else if (w_a_xfer) begin
            r_a_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_b_data  <= '0;
            r_b_valid <= 1'b0;
        end else if (w_s0_to_b) begin
            r_b_data  <= r_s0_data;
            r_b_valid <= 1'b1;
        end else if (w_b_xfer) begin
            r_b_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else begin
            if (w_a_xfer) r_count_a <= r_count_a + 16'd1;
            if (w_b_xfer) r_count_b <= r_count_b + 16'd1;
        end
    end

    assign o_out_a       = r_a_data;
    assign o_out_a_valid = r_a_valid;
    assign o_out_b       = r_b_data;
    assign o_out_b_valid = r_b_valid;
    assign o_count_a     = r_count_a;
    assign o_count_b     = r_count_b;

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed scenarios plus a random phase, with a
// per-port FIFO scoreboard checking data order and transfer counts.
module tb_demux;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         sel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_a;
    logic         out_a_valid;
    logic         a_ready = 1'b1;
    logic [W-1:0] out_b;
    logic         out_b_valid;
    logic         b_ready = 1'b1;
    logic [15:0]  count_a;
    logic [15:0]  count_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [15:0]  m_cnt_a = '0;
    logic [15:0]  m_cnt_b = '0;

    demux #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in          (in_data),
        .i_sel         (sel),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_out_a       (out_a),
        .o_out_a_valid (out_a_valid),
        .i_out_a_ready (a_ready),
        .o_out_b       (out_b),
        .o_out_b_valid (out_b_valid),
        .i_out_b_ready (b_ready),
        .o_count_a     (count_a),
        .o_count_b     (count_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic s, input logic v);
        in_data  = d;
        sel      = s;
        in_valid = v;
    endtask

    task automatic model_reset();
        q_a.delete();
        q_b.delete();
        m_cnt_a = '0;
        m_cnt_b = '0;
    endtask

    // Inputs only change just after a rising edge, so values seen at the
    // falling edge are exactly those the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count_a", {16'h0, count_a}, {16'h0, m_cnt_a});
            check("count_b", {16'h0, count_b}, {16'h0, m_cnt_b});
            if (out_a_valid && a_ready) begin
                check("a_word_expected", {31'h0, q_a.size() > 0}, 32'd1);
                if (q_a.size() > 0) check("a_order", out_a, q_a.pop_front());
                m_cnt_a = m_cnt_a + 16'd1;
            end
            if (out_b_valid && b_ready) begin
                check("b_word_expected", {31'h0, q_b.size() > 0}, 32'd1);
                if (q_b.size() > 0) check("b_order", out_b, q_b.pop_front());
                m_cnt_b = m_cnt_b + 16'd1;
            end
            if (in_valid && in_ready) begin
                if (sel) q_b.push_back(in_data);
                else     q_a.push_back(in_data);
            end
        end
    end

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_a_valid", {31'h0, out_a_valid}, 32'd0);
        check("rst_b_valid", {31'h0, out_b_valid}, 32'd0);
        check("rst_a_data", out_a, 32'd0);
        check("rst_b_data", out_b, 32'd0);
        check("rst_counts", {count_a, count_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic routing and two-edge latency
        drive(32'hA5A5_0001, 1'b0, 1'b1);
        tick();
        drive(32'h5A5A_0002, 1'b1, 1'b1);
        tick();
        check("basic_a_valid", {31'h0, out_a_valid}, 32'd1);
        check("basic_a_data", out_a, 32'hA5A5_0001);
        check("basic_b_empty", {31'h0, out_b_valid}, 32'd0);
        drive('0, 1'b0, 1'b0);
        tick();
        check("basic_b_valid", {31'h0, out_b_valid}, 32'd1);
        check("basic_b_data", out_b, 32'h5A5A_0002);
        check("basic_a_drained", {31'h0, out_a_valid}, 32'd0);
        check("basic_count_a", {16'h0, count_a}, 32'd1);
        tick();
        check("basic_b_drained", {31'h0, out_b_valid}, 32'd0);
        check("basic_count_b", {16'h0, count_b}, 32'd1);

        // Backpressure on port A
        a_ready = 1'b0;
        drive(32'h0000_0011, 1'b0, 1'b1);
        tick();
        drive(32'h0000_0012, 1'b0, 1'b1);
        tick();
        check("bp_a_valid", {31'h0, out_a_valid}, 32'd1);
        check("bp_in_ready_low", {31'h0, in_ready}, 32'd0);
        drive(32'h0000_0013, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_ready", {31'h0, in_ready}, 32'd0);
            check("bp_hold_data", out_a, 32'h0000_0011);
            check("bp_hold_valid", {31'h0, out_a_valid}, 32'd1);
        end
        a_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'h0, in_ready}, 32'd1);
        tick();
        check("bp_second", out_a, 32'h0000_0012);
        drive('0, 1'b0, 1'b0);
        tick();
        check("bp_third", out_a, 32'h0000_0013);
        tick();
        check("bp_drained", {31'h0, out_a_valid}, 32'd0);
        check("idle_retains", out_a, 32'h0000_0013);
        check("bp_count_a", {16'h0, count_a}, 32'd4);

        // Head-of-line blocking
        a_ready = 1'b0;
        drive(32'h0000_0021, 1'b0, 1'b1);
        tick();
        drive(32'h0000_0022, 1'b0, 1'b1);
        tick();
        drive(32'h0000_0023, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("hol_b_blocked", {31'h0, out_b_valid}, 32'd0);
            check("hol_in_ready", {31'h0, in_ready}, 32'd0);
            tick();
        end
        a_ready = 1'b1;
        tick();
        check("hol_b_still_blocked", {31'h0, out_b_valid}, 32'd0);
        drive('0, 1'b0, 1'b0);
        tick();
        check("hol_b_valid", {31'h0, out_b_valid}, 32'd1);
        check("hol_b_data", out_b, 32'h0000_0023);
        tick();
        check("hol_count_a", {16'h0, count_a}, 32'd6);
        check("hol_count_b", {16'h0, count_b}, 32'd2);

        // Streaming, alternating ports
        for (int i = 0; i < 100; i++) begin
            drive(32'hC000_0000 + W'(i), i[0], 1'b1);
            #1;
            check("stream_in_ready", {31'h0, in_ready}, 32'd1);
            tick();
        end
        drive('0, 1'b0, 1'b0);
        repeat (3) tick();
        check("stream_count_a", {16'h0, count_a}, 32'd56);
        check("stream_count_b", {16'h0, count_b}, 32'd52);

        // Random traffic and backpressure
        for (int i = 0; i < 3000; i++) begin
            drive($urandom, 1'($urandom), ($urandom_range(3) != 0));
            a_ready = ($urandom_range(2) != 0);
            b_ready = ($urandom_range(3) != 0);
            tick();
        end
        drive('0, 1'b0, 1'b0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 20 && (q_a.size() + q_b.size()) != 0; i++) tick();
        check("rand_drain_a", q_a.size(), 32'd0);
        check("rand_drain_b", q_b.size(), 32'd0);
        check("rand_valids", {30'h0, out_a_valid, out_b_valid}, 32'd0);

        // Counter wrap on port B
        rst_n = 1'b0;
        model_reset();
        #1;
        check("wrap_rst_counts", {count_a, count_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            drive(W'(i), 1'b1, 1'b1);
            tick();
        end
        drive('0, 1'b0, 1'b0);
        repeat (3) tick();
        check("wrap_count_b", {16'h0, count_b}, 32'd1);
        check("wrap_count_a", {16'h0, count_a}, 32'd0);

        // Asynchronous reset with both ports stalled and S0 full
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(32'h0000_0031, 1'b0, 1'b1);
        tick();
        drive(32'h0000_0032, 1'b1, 1'b1);
        tick();
        drive(32'h0000_0033, 1'b0, 1'b1);
        tick();
        drive('0, 1'b0, 1'b0);
        #1;
        check("mid_full_in_ready", {31'h0, in_ready}, 32'd0);
        check("mid_full_valids", {30'h0, out_a_valid, out_b_valid}, 32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_valids", {30'h0, out_a_valid, out_b_valid}, 32'd0);
        check("mid_a_data", out_a, 32'd0);
        check("mid_b_data", out_b, 32'd0);
        check("mid_counts", {count_a, count_b}, 32'd0);
        check("mid_in_ready", {31'h0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        drive(32'h0000_0041, 1'b1, 1'b1);
        tick();
        drive('0, 1'b0, 1'b0);
        tick();
        check("post_rst_b_data", out_b, 32'h0000_0041);
        check("post_rst_a_valid", {31'h0, out_a_valid}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter: WIDTH, default 32, data width of all data ports.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous active-low reset; 0 clears all state immediately, independent of Clk.
REQ-004 In  input  WIDTH  upstream data word.
REQ-005 Sel  input  1  route select for the word on In: 0 routes to port A, 1 routes to port B.
REQ-006 InValid  input  1  upstream asserts that In/Sel hold a word.
REQ-007 InReady  output  1  block can accept a word this cycle.
REQ-008 OutA  output  WIDTH  port A data.
REQ-009 OutAValid  output  1  OutA holds a word.
REQ-010 OutAReady  input  1  port A consumer accepts the word.
REQ-011 OutB  output  WIDTH  port B data.
REQ-012 OutBValid  output  1  OutB holds a word.
REQ-013 OutBReady  input  1  port B consumer accepts the word.
REQ-014 CountA  output  16  number of words transferred on port A.
REQ-015 CountB  output  16  number of words transferred on port B.

Function
REQ-016 Transfer definition: a transfer occurs on a rising edge when valid and ready are both 1 on the same port (In, A or B).
REQ-017 Structure:
- Stage S0 is a single-entry input register holding data, sel and s0_valid.
- Stage S1 has one output register per port: OutA/OutAValid and OutB/OutBValid.
REQ-018 In transfer: S0 captures In and Sel and sets s0_valid.
REQ-019 S0 advance: S0 advances on an edge when s0_valid=1 and its target port is empty, or its target port completes a transfer on that same edge.
REQ-020 On S0 advance:
- The target register loads the S0 data and its valid is set.
- s0_valid clears unless a new In transfer happens on the same edge.
REQ-021 InReady = !s0_valid || S0 advances this cycle; this is a combinational function of state and OutAReady/OutBReady.
REQ-022 Latency:
- A word accepted on edge k with its target port empty appears on OutA/OutB with Valid=1 after edge k+1.
- That is 2 cycles, matching the team's registered datapath latency.
REQ-023 Throughput: one word per cycle is sustained per stream when the consumer holds Ready=1.
REQ-024 Ordering: words leave in acceptance order; an S0 word blocked on a stalled port also blocks words bound for the other port (head-of-line blocking, no reordering).
REQ-025 Output hold: while OutXValid=1 and OutXReady=0, OutX and OutXValid stay stable.
REQ-026 Output drain: on a transfer with no new load, OutXValid clears on that edge.
REQ-027 Same-edge reload: on a port X transfer with S0 advancing to X on the same edge, OutXValid stays 1 and OutX takes the new word, with no bubble.
REQ-028 Idle data: when OutXValid=0, OutX retains its last loaded value.
REQ-029 Counters:
- CountA/CountB increment by 1 on each port A/B transfer.
- They wrap 16'hFFFF -> 16'h0000.
- Both ports may increment on the same edge.
REQ-030 Sel and In are ignored when no In transfer occurs.

Reset
REQ-031 Reset=0 asynchronously forces:
- s0_valid, OutAValid and OutBValid to 0.
- OutA, OutB and the S0 data/sel to 0.
- CountA and CountB to 0.
REQ-032 While Reset=0, InReady=1 (S0 is empty), and no transfer is counted.
REQ-033 Words held in S0 or S1 when reset asserts mid-operation are discarded.
REQ-034 The first In transfer after reset is the first edge with Reset=1 and InValid=1.

Verification
REQ-035 Basic routing:
- Stimulus: after reset, In=32'hA5A5_0001 with Sel=0 and InValid=1 for one cycle, then In=32'h5A5A_0002 with Sel=1; both Readys held at 1.
- Response: OutA=32'hA5A5_0001 with OutAValid two edges after acceptance; OutB=32'h5A5A_0002 one cycle later; CountA=1, CountB=1.
REQ-036 Backpressure:
- Stimulus: OutAReady=0; send 3 words with Sel=0.
- Response: the first is held on OutA; the second is held in S0; InReady=0; the third is not accepted until OutAReady=1.
- After release, the words appear in order and CountA=3.
REQ-037 Head-of-line blocking:
- Stimulus: OutAReady=0; send an A word, then another A word, then a B word.
- Response: OutBValid stays 0 until port A drains.
REQ-038 Streaming:
- Stimulus: 100 back-to-back words with alternating Sel; Readys held at 1.
- Response: InReady stays 1 throughout; CountA=50, CountB=50; the data sequence matches the input order per port.
REQ-039 Counter wrap:
- Stimulus: 65537 port B transfers.
- Response: CountB=1.
REQ-040 Mid-operation reset:
- Stimulus: with both ports stalled and S0 full, drive Reset=0 between clock edges.
- Response: all Valids, data and counters read 0 immediately; InReady=1.
